// File: rtl/video_timing_gen.sv
// Raster sync generator for the JAMMA scan path. It supports VGA 31 kHz and EGA 15 kHz, with mode changes on frame wrap only.
// Latency: counters advance on pix_ce. sync/blank outputs are registered one clk after the counter value they decode.
// Backpressure: none, the block is free-running. Optional VTG_FRAME_STROBE_EN adds frame_start/frame_cnt.
module video_timing_gen #(
   parameter int unsigned HW        = 11,
   parameter int unsigned VW        = 10,
   parameter int unsigned H_ACT     = 640,
   parameter int unsigned H_FP      = 16,
   parameter int unsigned H_SYNC    = 96,
   parameter int unsigned H_TOTAL   = 800,
   parameter int unsigned V_ACT     = 480,
   parameter int unsigned V_FP      = 10,
   parameter int unsigned V_SYNC    = 2,
   parameter int unsigned V_TOTAL   = 525,
   parameter int unsigned E_V_ACT   = 240,
   parameter int unsigned E_V_FP    = 4,
   parameter int unsigned E_V_SYNC  = 3,
   parameter int unsigned E_V_TOTAL = 262
) (
   input  logic          clk,
   input  logic          nReset,
   input  logic          ega,
   output logic          hsync,
   output logic          vsync,
   output logic          csync,
   output logic          blank,
   output logic [HW-1:0] hcount,
   output logic [VW-1:0] vcount,
   output logic          pix_ce,
   output logic          mode
`ifdef VTG_FRAME_STROBE_EN
   ,
   output logic          frame_start,
   output logic [7:0]    frame_cnt
`endif
);

   // Every compare value, including the exclusive end of each sync window, must fit its counter.
   if ((H_TOTAL > 2**HW) || (H_ACT + H_FP + H_SYNC >= 2**HW) ||
       (V_TOTAL > 2**VW) || (V_ACT + V_FP + V_SYNC >= 2**VW) ||
       (E_V_TOTAL > 2**VW) || (E_V_ACT + E_V_FP + E_V_SYNC >= 2**VW)) begin : gParamCheck
      $error("video_timing_gen: timing parameters do not fit HW/VW counter widths");
   end

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACT);
   localparam logic [HW-1:0] HS_BEG   = HW'(H_ACT + H_FP);
   localparam logic [HW-1:0] HS_END   = HW'(H_ACT + H_FP + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACT);
   localparam logic [VW-1:0] VS_BEG   = VW'(V_ACT + V_FP);
   localparam logic [VW-1:0] VS_END   = VW'(V_ACT + V_FP + V_SYNC);
   localparam logic [VW-1:0] EV_LAST  = VW'(E_V_TOTAL - 1);
   localparam logic [VW-1:0] EV_ACT_C = VW'(E_V_ACT);
   localparam logic [VW-1:0] EVS_BEG  = VW'(E_V_ACT + E_V_FP);
   localparam logic [VW-1:0] EVS_END  = VW'(E_V_ACT + E_V_FP + E_V_SYNC);

   logic          egaS1, egaS2;
   logic          divTog;
   logic [VW-1:0] vLast, vActive, vsBeg, vsEnd;
   logic          frameEnd, commit;

   // The vertical geometry follows the mode in effect, not the requested one.
   assign vLast   = mode ? EV_LAST  : V_LAST;
   assign vActive = mode ? EV_ACT_C : V_ACT_C;
   assign vsBeg   = mode ? EVS_BEG  : VS_BEG;
   assign vsEnd   = mode ? EVS_END  : VS_END;

   assign frameEnd = pix_ce && (hcount == H_LAST) && (vcount == vLast);
   assign commit   = frameEnd && (egaS2 != mode);

   // ega synchroniser, mode commit on frame wrap, and pixel-enable divider.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         egaS1  <= ega;
         egaS2  <= ega;
         mode   <= ega;
         divTog <= 1'b0;
         pix_ce <= 1'b0;
      end else begin
         egaS1 <= ega;
         egaS2 <= egaS1;
         if (commit) begin
            // The divider restarts as it does after reset, so a new EGA frame starts from a known phase.
            mode   <= egaS2;
            divTog <= 1'b0;
            pix_ce <= ~egaS2;
         end else if (mode) begin
            divTog <= ~divTog;
            pix_ce <= divTog;
         end else begin
            divTog <= 1'b0;
            pix_ce <= 1'b1;
         end
      end
   end

   // Pixel and line counters, advancing once per pixel enable.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         hcount <= '0;
         vcount <= '0;
      end else if (pix_ce) begin
         if (hcount == H_LAST) begin
            hcount <= '0;
            vcount <= (vcount == vLast) ? '0 : vcount + VW'(1);
         end else begin
            hcount <= hcount + HW'(1);
         end
      end
   end

   // Registered sync and blank decodes of the current counter values.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         hsync <= 1'b1;
         vsync <= 1'b1;
         csync <= 1'b1;
         blank <= 1'b0;
      end else begin
         hsync <= !((hcount >= HS_BEG) && (hcount < HS_END));
         vsync <= !((vcount >= vsBeg) && (vcount < vsEnd));
         csync <= !((hcount >= HS_BEG) && (hcount < HS_END)) &&
                  !((vcount >= vsBeg) && (vcount < vsEnd));
         blank <= (hcount >= H_ACT_C) || (vcount >= vActive);
      end
   end

`ifdef VTG_FRAME_STROBE_EN
   // One pulse per frame at the pixel enable of (0,0), plus a wrapping frame counter.
   always_ff @(posedge clk) begin
      if (!nReset) begin
         frame_start <= 1'b0;
         frame_cnt   <= 8'd0;
      end else begin
         frame_start <= pix_ce && (hcount == '0) && (vcount == '0);
         if (pix_ce && (hcount == '0) && (vcount == '0)) begin
            frame_cnt <= frame_cnt + 8'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen. It uses reduced geometry so that whole frames fit in a short run.
// It covers reset state, both modes, mode commit and cancel, mid-frame reset, and the optional frame strobe.
// The DUT has no backpressure. Outputs are sampled on the falling clock edge.
module tb_video_timing_gen;

   localparam int HW = 11;
   localparam int VW = 10;
   // Line: 8 active, 2 porch, 3 sync, 16 total. VGA: 6/1/2/12 lines. EGA: 4/1/1/8 lines.
   localparam int H_TOT  = 16;
   localparam int V_TOT  = 12;
   localparam int EV_TOT = 8;

   logic          clk = 1'b0;
   logic          nReset = 1'b0;
   logic          ega = 1'b0;
   logic          hsync, vsync, csync, blank, pix_ce, mode;
   logic [HW-1:0] hcount;
   logic [VW-1:0] vcount;
`ifdef VTG_FRAME_STROBE_EN
   logic          frame_start;
   logic [7:0]    frame_cnt;
`endif

   video_timing_gen #(
      .HW(HW), .VW(VW),
      .H_ACT(8), .H_FP(2), .H_SYNC(3), .H_TOTAL(H_TOT),
      .V_ACT(6), .V_FP(1), .V_SYNC(2), .V_TOTAL(V_TOT),
      .E_V_ACT(4), .E_V_FP(1), .E_V_SYNC(1), .E_V_TOTAL(EV_TOT)
   ) dut (
      .clk(clk), .nReset(nReset), .ega(ega),
      .hsync(hsync), .vsync(vsync), .csync(csync), .blank(blank),
      .hcount(hcount), .vcount(vcount), .pix_ce(pix_ce), .mode(mode)
`ifdef VTG_FRAME_STROBE_EN
      , .frame_start(frame_start), .frame_cnt(frame_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [HW-1:0] h;
      logic [VW-1:0] v;
      logic hs, vs, cs, bl, pc, md;
   } obs_t;

   typedef struct {
      int   t;
      obs_t exp;
   } vec_t;

   vec_t tab[$];
   int   errors = 0;
   int   checks = 0;
   int   curT = 0;

   function automatic vec_t mkv(int t, int h, int v, bit hs, bit vs, bit cs, bit bl, bit pc, bit md);
      vec_t r;
      r.t = t;
      r.exp.h = HW'(h);
      r.exp.v = VW'(v);
      r.exp.hs = hs; r.exp.vs = vs; r.exp.cs = cs;
      r.exp.bl = bl; r.exp.pc = pc; r.exp.md = md;
      return r;
   endfunction

   function automatic obs_t curObs();
      obs_t o;
      o.h = hcount; o.v = vcount;
      o.hs = hsync; o.vs = vsync; o.cs = csync;
      o.bl = blank; o.pc = pix_ce; o.md = mode;
      return o;
   endfunction

   function automatic bit sigv(int sel);
      case (sel)
         0:       return hsync;
         1:       return vsync;
         2:       return ~blank;
         default: return csync;
      endcase
   endfunction

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic doReset(input bit e);
      @(negedge clk);
      nReset = 1'b0;
      ega = e;
      @(negedge clk);
      nReset = 1'b1;
      curT = 0;
   endtask

   task automatic runTable(input string nm);
      obs_t o;
      foreach (tab[i]) begin
         while (curT < tab[i].t) begin
            @(negedge clk);
            curT++;
         end
         o = curObs();
         checks++;
         if (o !== tab[i].exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0d got h=%0d v=%0d hs%b vs%b cs%b bl%b pc%b md%b exp h=%0d v=%0d hs%b vs%b cs%b bl%b pc%b md%b",
                     nm, i, curT, o.h, o.v, o.hs, o.vs, o.cs, o.bl, o.pc, o.md,
                     tab[i].exp.h, tab[i].exp.v, tab[i].exp.hs, tab[i].exp.vs,
                     tab[i].exp.cs, tab[i].exp.bl, tab[i].exp.pc, tab[i].exp.md);
         end
      end
   endtask

   // Measures the fall-to-fall period and low time of the selected signal.
   task automatic measure(input int sel, input int expPer, input int expLow, input string nm);
      bit prev, c, ok;
      int per, low;
      prev = sigv(sel);
      c = prev;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         c = sigv(sel);
         if (prev && !c) begin
            ok = 1'b1;
            break;
         end
         prev = c;
      end
      if (!ok) begin
         chk({nm, "_first_edge_timeout"}, 0, 1);
         return;
      end
      per = 1; low = 1; prev = c; ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         c = sigv(sel);
         if (prev && !c) begin
            ok = 1'b1;
            break;
         end
         per++;
         if (!c) low++;
         prev = c;
      end
      if (!ok) begin
         chk({nm, "_second_edge_timeout"}, 0, 1);
         return;
      end
      chk({nm, "_period"}, per, expPer);
      chk({nm, "_low"}, low, expLow);
   endtask

   task automatic waitV(input int v);
      bit ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         curT++;
         if (vcount == VW'(v)) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("wait_vcount_timeout", 0, 1);
   endtask

   initial begin
      int  modeBad, n;
      bit  ok;

      // VGA from reset: t counts falling edges after the reset edge.
      tab.delete();
      tab.push_back(mkv(  0,  0, 0, 1, 1, 1, 0, 0, 0));
      tab.push_back(mkv(  1,  0, 0, 1, 1, 1, 0, 1, 0));
      tab.push_back(mkv(  2,  1, 0, 1, 1, 1, 0, 1, 0));
      tab.push_back(mkv( 10,  9, 0, 1, 1, 1, 1, 1, 0));
      tab.push_back(mkv( 12, 11, 0, 0, 1, 0, 1, 1, 0));
      tab.push_back(mkv( 15, 14, 0, 1, 1, 1, 1, 1, 0));
      tab.push_back(mkv( 17,  0, 1, 1, 1, 1, 1, 1, 0));
      tab.push_back(mkv( 18,  1, 1, 1, 1, 1, 0, 1, 0));
      tab.push_back(mkv( 98,  1, 6, 1, 1, 1, 1, 1, 0));
      tab.push_back(mkv(114,  1, 7, 1, 0, 0, 1, 1, 0));
      tab.push_back(mkv(146,  1, 9, 1, 1, 1, 1, 1, 0));
      tab.push_back(mkv(193,  0, 0, 1, 1, 1, 1, 1, 0));
      tab.push_back(mkv(194,  1, 0, 1, 1, 1, 0, 1, 0));
      doReset(1'b0);
`ifdef VTG_FRAME_STROBE_EN
      chk("reset_frame_cnt", frame_cnt, 0);
      chk("reset_frame_start", frame_start, 0);
`endif
      runTable("vga");
      measure(0, H_TOT, 3, "vga_hsync");
      measure(1, H_TOT * V_TOT, 2 * H_TOT, "vga_vsync");
      doReset(1'b0);
      measure(2, H_TOT, 8, "vga_blank");

      // EGA from reset: pixel enable on every second clk.
      tab.delete();
      tab.push_back(mkv(  0,  0, 0, 1, 1, 1, 0, 0, 1));
      tab.push_back(mkv(  1,  0, 0, 1, 1, 1, 0, 0, 1));
      tab.push_back(mkv(  2,  0, 0, 1, 1, 1, 0, 1, 1));
      tab.push_back(mkv(  3,  1, 0, 1, 1, 1, 0, 0, 1));
      tab.push_back(mkv( 22, 10, 0, 0, 1, 0, 1, 1, 1));
      tab.push_back(mkv( 27, 13, 0, 0, 1, 0, 1, 0, 1));
      tab.push_back(mkv( 28, 13, 0, 1, 1, 1, 1, 1, 1));
      tab.push_back(mkv(162,  0, 5, 1, 0, 0, 1, 1, 1));
      tab.push_back(mkv(194,  0, 6, 1, 1, 1, 1, 1, 1));
      tab.push_back(mkv(257,  0, 0, 1, 1, 1, 1, 0, 1));
      tab.push_back(mkv(258,  0, 0, 1, 1, 1, 0, 1, 1));
      doReset(1'b1);
      runTable("ega");
      measure(0, 2 * H_TOT, 6, "ega_hsync");
      measure(1, 2 * H_TOT * EV_TOT, 2 * H_TOT, "ega_vsync");
      doReset(1'b1);
      measure(2, 2 * H_TOT, 16, "ega_blank");

      // Mode request mid-frame: the commit happens only on the last pixel enable of the frame.
      doReset(1'b0);
      waitV(3);
      ega = 1'b1;
      modeBad = 0;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (mode != 1'b0) modeBad++;
         if (hcount == HW'(H_TOT - 1) && vcount == VW'(V_TOT - 1) && pix_ce) begin
            ok = 1'b1;
            break;
         end
      end
      chk("switch_frame_end_reached", ok, 1);
      chk("switch_mode_held", modeBad, 0);
      @(negedge clk);
      chk("switch_commit_state", {mode, hcount, vcount, pix_ce}, {1'b1, HW'(0), VW'(0), 1'b0});
      @(negedge clk);
      chk("switch_ce1", {hcount, pix_ce}, {HW'(0), 1'b0});
      @(negedge clk);
      chk("switch_ce2", {hcount, pix_ce}, {HW'(0), 1'b1});
      @(negedge clk);
      chk("switch_ce3", {hcount, pix_ce}, {HW'(1), 1'b0});
      measure(1, 2 * H_TOT * EV_TOT, 2 * H_TOT, "switch_vsync");
      measure(0, 2 * H_TOT, 6, "switch_hsync");

      // A short ega pulse withdrawn before the frame end is cancelled.
      ega = 1'b0;
      doReset(1'b0);
      waitV(3);
      ega = 1'b1;
      repeat (4) @(negedge clk);
      ega = 1'b0;
      modeBad = 0;
      for (int i = 0; i < 2 * H_TOT * V_TOT; i++) begin
         @(negedge clk);
         if (mode != 1'b0) modeBad++;
      end
      chk("cancel_mode_held", modeBad, 0);
      measure(1, H_TOT * V_TOT, 2 * H_TOT, "cancel_vsync");

      // Reset while vsync is low: counters clear, sync releases, and the next vsync is at its nominal place.
      doReset(1'b0);
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk);
         if (!vsync) begin
            ok = 1'b1;
            break;
         end
      end
      chk("midreset_vsync_seen", ok, 1);
      repeat (5) @(negedge clk);
      nReset = 1'b0;
      @(negedge clk);
      nReset = 1'b1;
      chk("midreset_counters", {hcount, vcount}, {HW'(0), VW'(0)});
      @(negedge clk);
      chk("midreset_vsync_high", vsync, 1);
      n = 1;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         if (!vsync) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
         n++;
      end
      chk("midreset_next_vsync_found", ok, 1);
      chk("midreset_next_vsync_t", n, 114);

`ifdef VTG_FRAME_STROBE_EN
      // One strobe per frame over 257 frames, and the counter wraps.
      begin
         int pulses, lastT, badInt;
         pulses = 0; lastT = 0; badInt = 0;
         doReset(1'b0);
         for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            curT++;
            if (frame_start) begin
               pulses++;
               if (pulses == 1) chk("strobe_first_t", curT, 2);
               else if (curT - lastT != H_TOT * V_TOT) badInt++;
               lastT = curT;
               if (pulses == 256) chk("strobe_cnt_256", frame_cnt, 0);
               if (pulses == 257) break;
            end
         end
         chk("strobe_pulses", pulses, 257);
         chk("strobe_bad_intervals", badInt, 0);
         chk("strobe_cnt_wrapped", frame_cnt, 1);
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
Synthesizable, parametrised successor to the fixed-period bench sync source. Generates hsync, vsync, csync and blanking for the JAMMA scan path in two runtime-selectable modes: VGA 31 kHz, or EGA/arcade 15 kHz via an internal ÷2 pixel enable. Exposes pixel and line counters so the scan-converter and frame-buffer logic can lock to them. Mode changes take effect only on frame boundaries, so sync stays glitch-free.

Parameters:
HW, 11, horizontal counter width
VW, 10, vertical counter width
H_ACT, 640, active pixels per line (both modes)
H_FP, 16, horizontal front porch, pixels
H_SYNC, 96, hsync width, pixels
H_TOTAL, 800, pixels per line
V_ACT, 480, VGA active lines
V_FP, 10, VGA front porch, lines
V_SYNC, 2, VGA vsync width, lines
V_TOTAL, 525, VGA lines per frame
E_V_ACT, 240, EGA active lines
E_V_FP, 4, EGA front porch, lines
E_V_SYNC, 3, EGA vsync width, lines
E_V_TOTAL, 262, EGA lines per frame

Ports:
clk  input  1  system clock (25 MHz nominal)
nReset  input  1  synchronous active-low reset
ega  input  1  requested mode: 0 = VGA, 1 = EGA 15 kHz
hsync  output  1  horizontal sync, active low
vsync  output  1  vertical sync, active low
csync  output  1  composite sync, active low
blank  output  1  high outside the active area
hcount  output  HW  current pixel index
vcount  output  VW  current line index
pix_ce  output  1  pixel enable (every clk in VGA, every 2nd clk in EGA)
mode  output  1  mode currently in effect

Behaviour:
- Reset and clock: single clock domain; reset sampled on rising clk while nReset = 0.
- Reset values: hcount = 0, vcount = 0, hsync = 1, vsync = 1, csync = 1, blank = 0, pix_ce = 0, ÷2 toggle = 0. `mode` loads the current value of `ega`.
- pix_ce:
  - mode 0: constantly 1 from the first cycle after reset.
  - mode 1: toggle register; pix_ce = 1 on alternate cycles, starting on the second cycle after reset.
- Counters advance only when pix_ce = 1.
  - hcount counts 0..H_TOTAL-1, then wraps to 0.
  - At the hcount wrap, vcount increments and wraps at VT-1.
  - VT = V_TOTAL in mode 0, E_V_TOTAL in mode 1; VA, VF, VS are selected the same way.
- Decodes are registered, one clk after the counter value they describe:
  - hsync = 0 iff H_ACT+H_FP ≤ hcount < H_ACT+H_FP+H_SYNC.
  - vsync = 0 iff VA+VF ≤ vcount < VA+VF+VS.
  - blank = 1 iff hcount ≥ H_ACT or vcount ≥ VA.
  - csync = hsync AND vsync.
- Mode switch:
  - `ega` is double-registered internally for synchronisation.
  - A pending mode is committed only on the pix_ce where hcount = H_TOTAL-1 and vcount = VT-1, i.e. the frame wrap.
  - The ÷2 toggle resets to 0 on the commit.
  - Toggling `ega` back before the frame end cancels the change; no partial frame in a new mode is ever produced.
- Reset asserted mid-frame: counters return to 0 on that clk and syncs deassert (high) the next clk. No stretched sync pulse is ever output.
- Widths: all comparisons unsigned, at HW/VW bits. Parameter sums must fit the counter width; this is checked with an elaboration-time $error.

Optional Feature:
VTG_FRAME_STROBE_EN.
- Defined: adds outputs `frame_start` (1 bit) and `frame_cnt` (8 bits).
  - frame_start is a one-clk pulse registered alongside the decodes, for hcount = 0, vcount = 0.
  - frame_cnt increments on each frame_start, wraps 255 → 0, and resets to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
1. Reset with ega = 0, run 2 frames. Required: hsync period 800 clk (32 µs at 40 ns), low for 96 clk; vsync period 420000 clk, low for 1600 clk; blank high for 160 of every 800 clk.
2. Reset with ega = 1. Required: pix_ce pattern 0101…; hsync period 1600 clk, low for 192 clk; vsync period 419200 clk, low for 4800 clk.
3. Raise ega at vcount = 100 in mode 0. Required: mode stays 0 until the hcount 799 / vcount 524 pix_ce; next frame is EGA timing from hcount = 0.
4. Pulse ega 1 → 0 within one frame in mode 0. Required: mode never changes; sync periods unchanged.
5. Drop nReset for one clk while vsync = 0. Required: hcount = vcount = 0 the next clk; vsync = 1 the clk after; the next vsync occurs at the nominal position.
6. With VTG_FRAME_STROBE_EN defined, run 257 VGA frames. Required: exactly one frame_start per 420000 clk; frame_cnt reads 1 after wrapping.
